// File: rtl/branch_pkg.sv
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types and constants for the branch redirect path:
//                FSM state encoding, RV32 branch funct3 codes and the
//                instruction size used for fall-through PC computation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    // Redirect controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // Branch-type funct3 encodings, shared with the branch unit
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Size of one instruction in bytes (fall-through increment)
    localparam int unsigned INSN_BYTES = 4;

endpackage : branch_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up-counter that sticks at its maximum value, with a
//                synchronous clear that overrides the increment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;

    // Clear wins over increment; increment stops once all ones is reached
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q_o = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
//  Module      : branch_redirect_ctrl
//  Description : Detects branch mispredictions from execute, issues a single
//                registered PC redirect to fetch over valid/ready, then holds
//                a pipeline flush for FLUSH_CYCLES cycles. Keeps saturating
//                branch / mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic             ex_taken_i,
    input  logic [XLEN-1:0]  ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [XLEN-1:0]  ex_pred_target_i,
    output logic             redir_valid_o,
    input  logic             redir_ready_i,
    output logic [XLEN-1:0]  redir_pc_o,
    output logic             flush_o,
    input  logic             clr_stats_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    // Flush down-counter only needs to hold FLUSH_CYCLES-1
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD =
        (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

    state_e            state_q;
    logic              redir_valid_q;
    logic              flush_q;
    logic [XLEN-1:0]   redir_pc_q;
    logic [FC_W-1:0]   fcnt_q;

    logic              acc_d;
    logic              mis_d;
    logic [XLEN-1:0]   correct_pc_d;

    // Ready depends on state only, so no input reaches ex_ready_o combinationally
    assign ex_ready_o = (state_q == ST_IDLE);

    // Accept, mispredict detection and corrected fetch PC (wraps modulo 2^XLEN)
    always_comb begin
        acc_d        = ex_valid_i & ex_ready_o;
        mis_d        = (ex_taken_i != ex_pred_taken_i) |
                       (ex_taken_i & (ex_target_i != ex_pred_target_i));
        correct_pc_d = ex_taken_i ? ex_target_i
                                  : (ex_pc_i + XLEN'(INSN_BYTES));
    end

    // Redirect/flush sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            redir_pc_q    <= '0;
            fcnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_d && mis_d) begin
                        state_q       <= ST_REDIRECT;
                        redir_valid_q <= 1'b1;
                        flush_q       <= 1'b1;
                        redir_pc_q    <= correct_pc_d;
                    end
                end
                ST_REDIRECT: begin
                    // redir_valid/redir_pc stay put until fetch takes them
                    if (redir_ready_i) begin
                        redir_valid_q <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            flush_q <= 1'b0;
                        end else begin
                            state_q <= ST_FLUSH;
                            fcnt_q  <= FC_LOAD;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q == '0) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - {{(FC_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    redir_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                end
            endcase
        end
    end

    assign redir_valid_o = redir_valid_q;
    assign redir_pc_o    = redir_pc_q;
    assign flush_o       = flush_q;

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (acc_d),
        .clr_i (clr_stats_i),
        .q_o   (branch_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (acc_d & mis_d),
        .clr_i (clr_stats_i),
        .q_o   (mispred_cnt_o)
    );

endmodule : branch_redirect_ctrl

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// ============================================================================
//  Module      : tb_branch_redirect_ctrl
//  Description : Bench for branch_redirect_ctrl. Two builds share stimulus:
//                A (FLUSH_CYCLES=2, CNT_W=32) and B (FLUSH_CYCLES=0, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        redir_ready = 1'b0;
    logic        clr_stats = 1'b0;

    logic        a_rdy, a_rv, a_fl;
    logic [31:0] a_pc, a_bc, a_mc;
    logic        b_rdy, b_rv, b_fl;
    logic [31:0] b_pc;
    logic [3:0]  b_bc, b_mc;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(a_rdy), .ex_pc_i(ex_pc),
        .ex_taken_i(ex_taken), .ex_target_i(ex_target),
        .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target),
        .redir_valid_o(a_rv), .redir_ready_i(redir_ready), .redir_pc_o(a_pc),
        .flush_o(a_fl), .clr_stats_i(clr_stats),
        .branch_cnt_o(a_bc), .mispred_cnt_o(a_mc)
    );

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(b_rdy), .ex_pc_i(ex_pc),
        .ex_taken_i(ex_taken), .ex_target_i(ex_target),
        .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target),
        .redir_valid_o(b_rv), .redir_ready_i(redir_ready), .redir_pc_o(b_pc),
        .flush_o(b_fl), .clr_stats_i(clr_stats),
        .branch_cnt_o(b_bc), .mispred_cnt_o(b_mc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: "redirect pending" flag plus remaining flush cycles
    // per build; counters are plain integers clipped at their maximum.
    // ------------------------------------------------------------------
    int          m_fc  [2] = '{2, 0};
    longint      m_max [2] = '{64'hFFFF_FFFF, 64'd15};
    bit          m_rv  [2];
    int          m_left[2];
    logic [31:0] m_pc  [2];
    longint      m_bc  [2];
    longint      m_mc  [2];

    task automatic model_update();
        bit          mis, ready, acc;
        logic [31:0] cpc;
        mis = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
        cpc = ex_taken ? ex_target : ex_pc + 32'd4;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_rv[k] = 0; m_left[k] = 0; m_pc[k] = '0; m_bc[k] = 0; m_mc[k] = 0;
            end else begin
                ready = !m_rv[k] && (m_left[k] == 0);
                acc   = ex_valid && ready;
                if (clr_stats) begin
                    m_bc[k] = 0; m_mc[k] = 0;
                end else begin
                    if (acc && m_bc[k] < m_max[k]) m_bc[k]++;
                    if (acc && mis && m_mc[k] < m_max[k]) m_mc[k]++;
                end
                if (m_rv[k]) begin
                    if (redir_ready) begin
                        m_rv[k] = 0;
                        m_left[k] = m_fc[k];
                    end
                end else if (m_left[k] > 0) begin
                    m_left[k]--;
                end else if (acc && mis) begin
                    m_rv[k] = 1;
                    m_pc[k] = cpc;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("A.ex_ready",    a_rdy, (!m_rv[0] && m_left[0] == 0));
        chk("A.redir_valid", a_rv,  m_rv[0]);
        chk("A.flush",       a_fl,  (m_rv[0] || m_left[0] > 0));
        chk("A.redir_pc",    a_pc,  m_pc[0]);
        chk("A.branch_cnt",  a_bc,  m_bc[0]);
        chk("A.mispred_cnt", a_mc,  m_mc[0]);
        chk("B.ex_ready",    b_rdy, (!m_rv[1] && m_left[1] == 0));
        chk("B.redir_valid", b_rv,  m_rv[1]);
        chk("B.flush",       b_fl,  (m_rv[1] || m_left[1] > 0));
        chk("B.redir_pc",    b_pc,  m_pc[1]);
        chk("B.branch_cnt",  b_bc,  m_bc[1]);
        chk("B.mispred_cnt", b_mc,  m_mc[1]);
    endtask

    // One clock: advance the model with the inputs present before the edge,
    // then compare just after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (expected values are for build A)
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst_n, v;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptg;
        logic        rr, clr;
        logic        e_rdy, e_rv, e_fl;
        logic [31:0] e_pc;
        int          e_bc, e_mc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [31:0] pc, logic tk,
                                logic [31:0] tgt, logic pt, logic [31:0] ptg,
                                logic rr, logic clr, logic rdy, logic rv,
                                logic fl, logic [31:0] epc, int bc, int mc);
        vec_t t;
        t.rst_n = r; t.v = v; t.pc = pc; t.tk = tk; t.tgt = tgt; t.pt = pt;
        t.ptg = ptg; t.rr = rr; t.clr = clr; t.e_rdy = rdy; t.e_rv = rv;
        t.e_fl = fl; t.e_pc = epc; t.e_bc = bc; t.e_mc = mc;
        return t;
    endfunction

    task automatic drive(logic r, logic v, logic [31:0] pc, logic tk, logic [31:0] tgt,
                         logic pt, logic [31:0] ptg, logic rr, logic clr);
        rst_n = r; ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptg; redir_ready = rr; clr_stats = clr;
    endtask

    initial begin
        // reset state
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,          1,0,0,32'h0,0,0));
        // correct not-taken then correct taken, back-to-back
        tbl.push_back(mk(1,1,32'h100,0,0,0,0,0,0,    1,0,0,32'h0,1,0));
        tbl.push_back(mk(1,1,32'h104,1,32'h200,1,32'h200,0,0, 1,0,0,32'h0,2,0));
        // taken mispredicted as not-taken, fetch ready immediately
        tbl.push_back(mk(1,1,32'h100,1,32'h140,0,0,1,0, 0,1,1,32'h140,3,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,          0,0,1,32'h140,3,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,          0,0,1,32'h140,3,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          1,0,0,32'h140,3,1));
        // not-taken mispredicted as taken, fetch stalls 4 cycles, pulses ignored
        tbl.push_back(mk(1,1,32'h2000,0,0,1,32'h3000,0,0, 0,1,1,32'h2004,4,2));
        tbl.push_back(mk(1,1,32'h500,1,32'h600,0,0,0,0,   0,1,1,32'h2004,4,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          0,1,1,32'h2004,4,2));
        tbl.push_back(mk(1,1,32'h500,1,32'h600,0,0,0,0,   0,1,1,32'h2004,4,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          0,1,1,32'h2004,4,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,          0,0,1,32'h2004,4,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          0,0,1,32'h2004,4,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          1,0,0,32'h2004,4,2));
        // wrong target
        tbl.push_back(mk(1,1,32'h40,1,32'h80,1,32'h90,1,0, 0,1,1,32'h80,5,3));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,          0,0,1,32'h80,5,3));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          0,0,1,32'h80,5,3));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          1,0,0,32'h80,5,3));
        // fall-through wrap to zero, then reset while in REDIRECT
        tbl.push_back(mk(1,1,32'hFFFF_FFFC,0,0,1,0,0,0, 0,1,1,32'h0,6,4));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          0,1,1,32'h0,6,4));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,          1,0,0,32'h0,0,0));
        // clr_stats with simultaneous accepted mispredict
        tbl.push_back(mk(1,1,32'h100,1,32'h140,0,0,0,1, 0,1,1,32'h140,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,          0,0,1,32'h140,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          0,0,1,32'h140,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,          1,0,0,32'h140,0,0));

        #2;
        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].pc, tbl[i].tk, tbl[i].tgt,
                  tbl[i].pt, tbl[i].ptg, tbl[i].rr, tbl[i].clr);
            step();
            chk($sformatf("vec%0d.ex_ready", i),    a_rdy, tbl[i].e_rdy);
            chk($sformatf("vec%0d.redir_valid", i), a_rv,  tbl[i].e_rv);
            chk($sformatf("vec%0d.flush", i),       a_fl,  tbl[i].e_fl);
            chk($sformatf("vec%0d.redir_pc", i),    a_pc,  tbl[i].e_pc);
            chk($sformatf("vec%0d.branch_cnt", i),  a_bc,  tbl[i].e_bc);
            chk($sformatf("vec%0d.mispred_cnt", i), a_mc,  tbl[i].e_mc);
        end

        // FLUSH_CYCLES=0 build: flush tracks the REDIRECT cycles exactly
        drive(1,1,32'h300,1,32'h340,0,0,0,0);
        step();
        chk("fc0.enter.flush", b_fl, 1); chk("fc0.enter.rv", b_rv, 1);
        drive(1,0,0,0,0,0,0,0,0);
        step();
        step();
        chk("fc0.stall.flush", b_fl, 1); chk("fc0.stall.pc", b_pc, 32'h340);
        redir_ready = 1'b1;
        step();
        chk("fc0.hs.flush", b_fl, 0); chk("fc0.hs.rv", b_rv, 0); chk("fc0.hs.rdy", b_rdy, 1);
        chk("fc2.hs.flush", a_fl, 1); chk("fc2.hs.rdy", a_rdy, 0);
        redir_ready = 1'b0;
        step();
        step();
        chk("fc2.done.flush", a_fl, 0); chk("fc2.done.rdy", a_rdy, 1);

        // Saturation: 20 correct branches into a 4-bit counter
        drive(0,0,0,0,0,0,0,0,0);
        step();
        drive(1,1,32'h10,0,0,0,0,0,0);
        for (int i = 0; i < 20; i++) step();
        chk("sat.B.branch_cnt", b_bc, 15);
        chk("sat.B.mispred_cnt", b_mc, 0);
        chk("sat.A.branch_cnt", a_bc, 20);
        drive(1,0,0,0,0,0,0,0,0);
        step();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc, tgt;
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            tgt = pc + {$urandom_range(0, 255), 2'b00};
            drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, pc,
                  $urandom_range(0, 1) == 1, tgt, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? tgt + 32'd4 : tgt,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_branch_redirect_ctrl

`default_nettype wire
